// File: rtl/dmem_lsu_port.sv
// Load/store initiator for one port of the two-port data memory (RV32 byte access to word memory).
// Optional build macro MISALIGN_TRAP_EN: misaligned halfword/word accesses fault instead of being aligned down.
module dmem_lsu_port #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH+1:0]   req_addr,
  input  logic [2:0]              req_funct3,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wr_data,
  output logic [3:0]              mem_byteenable,
  input  logic [DATA_WIDTH-1:0]   mem_rd_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t                  state_reg;
  logic                    req_ready_reg;
  logic                    rsp_valid_reg;
  logic [DATA_WIDTH-1:0]   rsp_rdata_reg;
  logic                    rsp_err_reg;
  logic                    mem_we_reg;
  logic [ADDR_WIDTH-1:0]   mem_addr_reg;
  logic [DATA_WIDTH-1:0]   mem_wr_data_reg;
  logic [3:0]              mem_be_reg;
  logic [1:0]              lane_reg;
  logic [2:0]              funct3_reg;
  logic                    is_store_reg;

  // Request decode, evaluated combinationally from the request inputs.
  logic [1:0]              size_dec;
  logic                    illegal_f3;
  logic                    misalign;
  logic                    fault_dec;
  logic [1:0]              lane_dec;
  logic [3:0]              be_dec;
  logic [DATA_WIDTH-1:0]   wd_dec;

  assign size_dec   = req_funct3[1:0];
  assign illegal_f3 = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                      (req_we && req_funct3[2]);

`ifdef MISALIGN_TRAP_EN
  assign misalign = ((size_dec == 2'd1) && req_addr[0]) ||
                    ((size_dec == 2'd2) && (req_addr[1:0] != 2'b00));
  assign lane_dec = req_addr[1:0];
`else
  // Misaligned low bits are silently dropped so the access stays inside one word.
  assign misalign = 1'b0;
  always_comb begin
    lane_dec = 2'b00;
    case (size_dec)
      2'd0:    lane_dec = req_addr[1:0];
      2'd1:    lane_dec = {req_addr[1], 1'b0};
      default: lane_dec = 2'b00;
    endcase
  end
`endif

  assign fault_dec = illegal_f3 || misalign;

  always_comb begin
    be_dec = 4'b1111;
    case (size_dec)
      2'd0:    be_dec = 4'b0001 << lane_dec;
      2'd1:    be_dec = lane_dec[1] ? 4'b1100 : 4'b0011;
      default: be_dec = 4'b1111;
    endcase
  end

  // Each write lane carries the store byte that would land there after replication.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_wr_lane
      always_comb begin
        wd_dec[8*gi +: 8] = req_wdata[8*gi +: 8];
        case (size_dec)
          2'd0:    wd_dec[8*gi +: 8] = req_wdata[7:0];
          2'd1:    wd_dec[8*gi +: 8] = req_wdata[8*(gi%2) +: 8];
          default: wd_dec[8*gi +: 8] = req_wdata[8*gi +: 8];
        endcase
      end
    end
  endgenerate

  // Load alignment and extension of the captured read word.
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;
  logic [DATA_WIDTH-1:0]   load_ext;

  always_comb begin
    byte_sel = mem_rd_data[7:0];
    case (lane_reg)
      2'd0:    byte_sel = mem_rd_data[7:0];
      2'd1:    byte_sel = mem_rd_data[15:8];
      2'd2:    byte_sel = mem_rd_data[23:16];
      default: byte_sel = mem_rd_data[31:24];
    endcase
    half_sel = lane_reg[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];
  end

  always_comb begin
    load_ext = mem_rd_data;
    case (funct3_reg)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = mem_rd_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      req_ready_reg   <= 1'b1;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_err_reg     <= 1'b0;
      mem_we_reg      <= 1'b0;
      mem_addr_reg    <= '0;
      mem_wr_data_reg <= '0;
      mem_be_reg      <= 4'b0000;
      lane_reg        <= 2'b00;
      funct3_reg      <= 3'b000;
      is_store_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            req_ready_reg <= 1'b0;
            if (fault_dec) begin
              // Faults bypass the memory entirely and answer at once.
              state_reg     <= RESP;
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b1;
              rsp_rdata_reg <= '0;
            end else begin
              state_reg    <= ACCESS;
              mem_addr_reg <= req_addr[ADDR_WIDTH+1:2];
              mem_be_reg   <= be_dec;
              mem_we_reg   <= req_we;
              if (req_we) begin
                mem_wr_data_reg <= wd_dec;
              end
              lane_reg     <= lane_dec;
              funct3_reg   <= req_funct3;
              is_store_reg <= req_we;
            end
          end
        end
        ACCESS: begin
          mem_we_reg <= 1'b0;
          mem_be_reg <= 4'b0000;
          if (is_store_reg) begin
            state_reg     <= RESP;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
          end else begin
            state_reg <= CAPTURE;
          end
        end
        CAPTURE: begin
          state_reg     <= RESP;
          rsp_valid_reg <= 1'b1;
          rsp_err_reg   <= 1'b0;
          rsp_rdata_reg <= load_ext;
        end
        RESP: begin
          if (rsp_ready) begin
            state_reg     <= IDLE;
            rsp_valid_reg <= 1'b0;
            req_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign req_ready      = req_ready_reg;
  assign rsp_valid      = rsp_valid_reg;
  assign rsp_rdata      = rsp_rdata_reg;
  assign rsp_err        = rsp_err_reg;
  assign mem_we         = mem_we_reg;
  assign mem_addr       = mem_addr_reg;
  assign mem_wr_data    = mem_wr_data_reg;
  assign mem_byteenable = mem_be_reg;

endmodule

// File: doc/dmem_lsu_port.md
# dmem_lsu_port

Initiator for one port of the two-port data memory (`mem_2p`), placed between the RV32 load/store stage and memory port A or B. It accepts byte-addressed load/store requests over a valid/ready handshake and drives the word-addressed memory port with byte enables and lane-replicated write data. It captures the synchronous read word, then aligns and sign- or zero-extends it. It returns one response per request over a valid/ready handshake.

## Interface
Parameters:
- `ADDR_WIDTH`, 15, memory word-address width; byte address is `ADDR_WIDTH+2` bits.
- `DATA_WIDTH`, 32, fixed at 32 (RV32); other values unsupported.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_WIDTH+2  byte address.
- `req_funct3`  in  3  access size. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `req_wdata`  in  32  store data, right-justified.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  access fault.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_WIDTH  word address.
- `mem_wr_data`  out  32  lane-replicated write data.
- `mem_byteenable`  out  4  byte lanes.
- `mem_rd_data`  in  32  memory read word, valid the cycle after the address is sampled.

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- `req_ready` = (state == IDLE). A request is accepted on a rising edge where `req_valid && req_ready`.
- On acceptance, the request is registered and decoded:
  - `mem_addr` = `req_addr[ADDR_WIDTH+1:2]`.
  - Byte access: byteenable = 1 << `addr[1:0]`; write data = {4{`wdata[7:0]`}}.
  - Halfword access: byteenable = `addr[1]` ? 1100 : 0011; write data = {2{`wdata[15:0]`}}.
  - Word access: byteenable = 1111; write data = `wdata`.
- Transitions:
  - IDLE→ACCESS on acceptance of a legal request.
  - IDLE→RESP on acceptance of a faulting request. The memory is not touched and `rsp_err` = 1.
  - ACCESS→RESP for a store.
  - ACCESS→CAPTURE for a load.
  - CAPTURE→RESP; at this edge `rsp_rdata` is registered from `mem_rd_data`.
  - RESP→IDLE on `rsp_valid && rsp_ready`.
- `mem_we` = 1 only in ACCESS with a store. `mem_byteenable` is nonzero only in ACCESS, for loads and stores. `mem_addr` and `mem_wr_data` hold their last values elsewhere.
- Load extraction:
  - Byte: lane `addr[1:0]`; LB sign-extends bit 7, LBU zero-extends.
  - Halfword: half `addr[1]`; LH sign-extends bit 15, LHU zero-extends.
  - Word: passed through unchanged.
- Illegal funct3 always faults: 011, 110, 111, and any store with funct3[2] = 1.

## Timing
- Reset values (asynchronous): state IDLE, `req_ready` 1, `rsp_valid` 0, `rsp_rdata` 0, `rsp_err` 0, `mem_we` 0, `mem_addr` 0, `mem_wr_data` 0, `mem_byteenable` 0.
- Cycle numbering: acceptance at edge E0.
  - Store: ACCESS during cycle E0–E1; memory commits at E1; `rsp_valid` high from E1.
  - Load: ACCESS E0–E1, CAPTURE E1–E2; `rsp_valid` and `rsp_rdata` from E2.
  - Fault: `rsp_valid` from E0.
- While `rsp_valid` = 1 and `rsp_ready` = 0, `rsp_rdata` and `rsp_err` are held stable.
- If `rsp_ready` is already 1 when RESP is entered, the response completes in one cycle and IDLE is re-entered next cycle.
- Minimum request spacing: 3 cycles for stores, 4 for loads, 2 for faults.
- `req_valid` is ignored outside IDLE.
- Reset asserted mid-operation: all outputs return to reset values immediately. A pending response is discarded. A store whose ACCESS cycle is cut before E1 is not committed.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - A halfword access with `addr[0]` = 1 faults.
  - A word access with `addr[1:0]` ≠ 0 faults.
  - A faulting access gives `rsp_err` = 1 and `rsp_rdata` = 0, with no memory activity.
- Not defined:
  - Misaligned low address bits are forced to zero (halfword clears bit 0, word clears bits 1:0).
  - The access proceeds normally; `rsp_err` is raised only for illegal funct3.

## Test plan
- Reset: assert `rst_n` = 0 during ACCESS of an SW → `mem_we` falls to 0 without waiting for a clock edge. After release, `req_ready` = 1 and `rsp_valid` = 0, and that memory word is unchanged.
- SW to 0x0008 with data 0xDEADBEEF → one ACCESS cycle with `mem_addr` = 2, byteenable 1111, `mem_wr_data` 0xDEADBEEF, `mem_we` = 1. `rsp_valid` rises at the next edge with `rsp_err` = 0.
- SB to 0x0007 with data 0x000000A5 → byteenable 1000, `mem_wr_data` 0xA5A5A5A5. A following LB from 0x0007 returns 0xFFFFFFA5; LBU returns 0x000000A5.
- Memory word 0x80011234 at 0x0004. LH from 0x0006 → 0xFFFF8001; LHU from 0x0006 → 0x00008001; LW from 0x0004 → 0x80011234. Each `rsp_valid` appears 2 edges after acceptance.
- Backpressure: hold `rsp_ready` = 0 for 5 cycles in RESP → `rsp_valid`, `rsp_rdata` and `rsp_err` stay stable, `req_ready` = 0, and concurrent `req_valid` is not accepted.
- Faults:
  - LW from 0x0005 with the macro → `rsp_err` = 1, `rsp_rdata` = 0, no nonzero byteenable, `rsp_valid` at E0.
  - Same request without the macro → `mem_addr` = 1, byteenable 1111, `rsp_err` = 0.
  - funct3 = 011 faults in both builds.
